// File: rtl/jpeg_idct_serialize_if.sv
// Stream bundle for jpeg_idct_serialize: 4-lane beat input side and
// indexed single-sample output side.
interface jpeg_idct_serialize_if #(
   parameter int DATA_W = 32
);
   logic              inport_valid;
   logic [DATA_W-1:0] inport_data0;
   logic [DATA_W-1:0] inport_data1;
   logic [DATA_W-1:0] inport_data2;
   logic [DATA_W-1:0] inport_data3;
   logic [3:0]        inport_idx;
   logic              ready;
   logic              v;
   logic [DATA_W-1:0] outport_data;
   logic [5:0]        outport_idx;
   logic              yumi;

   // slave = the serializer; master = upstream producer plus downstream consumer
   modport slave (
      input  inport_valid, inport_data0, inport_data1, inport_data2, inport_data3,
      input  inport_idx, yumi,
      output ready, v, outport_data, outport_idx
   );

   modport master (
      output inport_valid, inport_data0, inport_data1, inport_data2, inport_data3,
      output inport_idx, yumi,
      input  ready, v, outport_data, outport_idx
   );
endinterface

// File: rtl/jpeg_idct_serialize.sv
// Ping-pong 4:1 serializer: collects a 64-sample block as 16 four-lane beats,
// then streams it out one sample per cycle in raster order with a 6-bit index.
module jpeg_idct_serialize #(
   parameter int DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  img_start_i,
   jpeg_idct_serialize_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE} state_t;

   state_t            r_state;
   logic [1:0]        r_block_ready;
   logic              r_block_wr;
   logic              r_block_rd;
   logic [5:0]        r_rd_idx;
   logic              r_v;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] r_mem [4][32];

   logic              w_wr_en;
   logic              w_wr_done;
   logic              w_rd_take;
   logic              w_rd_done;
   logic [5:0]        w_rd_addr;

   assign bus.ready        = ~r_block_ready[r_block_wr];
   assign bus.v            = r_v;
   assign bus.outport_data = r_out_data;
   assign bus.outport_idx  = r_rd_idx;

   assign w_wr_en   = bus.inport_valid & bus.ready;
   assign w_wr_done = w_wr_en & (bus.inport_idx == 4'd15);
   assign w_rd_take = (r_state == S_ACTIVE) & bus.yumi;
   assign w_rd_done = w_rd_take & (r_rd_idx == 6'd63);
   // Look one sample ahead on a take so the registered output keeps one/cycle.
   assign w_rd_addr = w_rd_take ? r_rd_idx + 6'd1 : r_rd_idx;

   // NOTE: the sample banks carry no reset; block_ready gates every read, so
   // their power-up contents are never observed as valid output.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_mem[0][{r_block_wr, bus.inport_idx}] <= bus.inport_data0;
         r_mem[1][{r_block_wr, bus.inport_idx}] <= bus.inport_data1;
         r_mem[2][{r_block_wr, bus.inport_idx}] <= bus.inport_data2;
         r_mem[3][{r_block_wr, bus.inport_idx}] <= bus.inport_data3;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out_data <= '0;
      end else if (r_state != S_IDLE) begin
         r_out_data <= r_mem[w_rd_addr[1:0]][{r_block_rd, w_rd_addr[5:2]}];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || img_start_i) begin
         r_state       <= S_IDLE;
         r_block_ready <= 2'b00;
         r_block_wr    <= 1'b0;
         r_block_rd    <= 1'b0;
         r_rd_idx      <= 6'd0;
         r_v           <= 1'b0;
      end else begin
         // Write and read completions always target opposite blocks.
         if (w_wr_done) begin
            r_block_ready[r_block_wr] <= 1'b1;
            r_block_wr                <= ~r_block_wr;
         end
         if (w_rd_done) begin
            r_block_ready[r_block_rd] <= 1'b0;
            r_block_rd                <= ~r_block_rd;
         end

         case (r_state)
            S_IDLE: begin
               if (r_block_ready[r_block_rd]) r_state <= S_SETUP;
            end
            S_SETUP: begin
               r_rd_idx <= 6'd0;
               r_v      <= 1'b1;
               r_state  <= S_ACTIVE;
            end
            S_ACTIVE: begin
               if (bus.yumi) begin
                  r_rd_idx <= r_rd_idx + 6'd1;
                  if (r_rd_idx == 6'd63) begin
                     r_v     <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_v     <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
